key_expansion: RTL and testbench
================================

# key_expansion

Generates the AES-128 round keys on the fly, one 128-bit round key per clock, from a 128-bit cipher key. It sits directly upstream of the cipher datapath and drives that stage's `roundKey` input. Round 0 (the raw key) is presented first, then rounds 1..10. `done` marks the final key so the cipher can apply its last-round transform and freeze.

## Interface
- No parameters. The key length is fixed at 128 bits, Nk=4 and Nr=10.
- Reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous reset, active-low. Low clears all state immediately.
- `start` in 1: pulse that loads `key` and begins an expansion.
- `key` in 128: cipher key. Word 0 is `key[127:96]`. Sampled only on the `start` edge.
- `roundKey` out 128: current round key, registered. Word 0 is `[127:96]`.
- `round` out 4: index of the round key currently on `roundKey` (0..10).
- `valid` out 1: `roundKey` holds a fresh key for this cycle.
- `done` out 1: the key for round 10 has been reached. Stays high until the next `start` or reset.

## Operation
- State machine `IDLE`, `EXPAND`, `DONE`. Reset state is `IDLE`.
- **Reset values:** `roundKey`=0, `round`=0, `valid`=0, `done`=0, internal `rcon`=8'h01.
- **IDLE:** outputs hold. `start`=1 at an edge loads the key, so that `roundKey`←`key`, `round`←0, `rcon`←8'h01, and the state moves to `EXPAND`.
- **EXPAND:** each edge, `roundKey`←`next_key(roundKey, rcon)`, `round`←`round`+1, and `rcon`←`xtime(rcon)`.
  - `next_key` works on words w0..w3:
    - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - RotWord(w) = {w[23:0], w[31:24]}.
  - `xtime(x)` = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - The rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- **Leaving EXPAND:** on the edge where `round` goes 9→10, the state moves to `DONE`.
- **DONE:** `roundKey` and `round` hold at the round-10 values. `valid`=0, `done`=1.
- **Output decode:** `valid` = (state==`EXPAND`) || (state==`DONE` && first cycle). `done` = (round==10).
  - Both are registered alongside the state, with no combinational path from inputs.
- **start mid-expansion:** `start` in `EXPAND` or `DONE` restarts immediately. The load behaviour is identical to the one from `IDLE`, and `done` drops on that edge.
- **start with reset:** `start` has no effect while `reset` is low.
- **Reset mid-operation:** asserting `reset` at any time returns every output to its reset value asynchronously.

## Timing
- Start to round-0 key: 1 cycle, since `roundKey`=`key` on the edge that samples `start`.
- Round n key appears n cycles after round 0. Round 10 appears 10 cycles after round 0, i.e. 11 cycles after `start`.
- `valid` is high for exactly 11 consecutive cycles, covering rounds 0..10.
- `done` rises in the same cycle that the round-10 key is visible. The cipher samples `done` and the final key together.
- The combinational path per cycle is one SubWord (4 S-box lookups) plus 5 XOR levels. There is no multicycle path.

## Structure
- Shared package `aes_pkg` holds:
  - the S-box table as a constant function `sbox(byte)`;
  - `xtime`;
  - localparams `NR`=10 and `RCON_INIT`=8'h01;
  - the `keyexp_state_t` enum `{IDLE, EXPAND, DONE}`.
- Sub-module `subword`: 32-bit combinational SubWord built from four `sbox` lookups. It is reusable by the 192/256 variants later.
- The top level contains the state register, round counter, rcon register, and `next_key` XOR network.

## Test plan
- **FIPS-197 A.1 vector:** `key`=2b7e151628aed2a6abf7158809cf4f3c with a `start` pulse gives:
  - round 0 = the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done`=1 in that cycle.
- **Control timing:** count `valid` and check `round`.
  - `valid` must be high for exactly 11 cycles.
  - `round` must step 0..10 monotonically.
  - The following cycle must show `valid`=0, `done`=1, and `roundKey` unchanged.
- **Restart:** assert `start` with `key`=0 at round 5. Next cycle must show `roundKey`=0, `round`=0, `done`=0. Round 1 must then equal 62636363626363636263636362636363.
- **Async reset:** drive `reset` low mid-cycle at round 7. All outputs go to 0 before the next clock edge. The block stays in `IDLE` until a new `start`.
- **Back-to-back:** `start` in the `DONE` cycle with the A.1 key regenerates the identical 11-key sequence, including `rcon` restarting at 01.
- **Reset with start:** `start` held high while `reset` is low gives no load. The first edge after `reset` rises with `start`=1 presents round 0.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, S-box lookup, GF(2^8) doubling and key-expansion state type.
package aes_pkg;
  localparam logic [3:0] NR = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} keyexp_state_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/subword.sv
// subword: 32-bit AES SubWord, four parallel S-box lookups.
module subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);
  assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
endmodule

// File: rtl/key_expansion.sv
// key_expansion: AES-128 on-the-fly round key generator, one round key per clock.
module key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic [127:0] roundKey,
  output logic [3:0]   round,
  output logic         valid,
  output logic         done
);
  keyexp_state_t state;
  logic [7:0] rcon;
  logic [31:0] w0, w1, w2, w3, sw, t, n0, n1, n2, n3;
  assign {w0, w1, w2, w3} = roundKey;
  subword u_subword (.word({w3[23:0], w3[31:24]}), .sub(sw));
  assign t  = sw ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      roundKey <= '0;
      round    <= '0;
      rcon     <= RCON_INIT;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      state    <= EXPAND;
      roundKey <= key;
      round    <= '0;
      rcon     <= RCON_INIT;
      valid    <= 1'b1;
      done     <= 1'b0;
    end else if (state == EXPAND) begin
      // valid stays high into the first DONE cycle so round 10 is flagged fresh
      roundKey <= {n0, n1, n2, n3};
      round    <= round + 4'd1;
      rcon     <= xtime(rcon);
      valid    <= 1'b1;
      done     <= (round == NR - 4'd1);
      state    <= (round == NR - 4'd1) ? DONE : EXPAND;
    end else if (state == DONE) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: scoreboarded random and directed checks against a FIPS-style key schedule model.
module tb_key_expansion;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] roundKey;
  logic [3:0] round;
  logic valid, done;
  typedef struct packed {logic [127:0] k; logic [3:0] r; logic d;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [7:0] sb_ref [256];
  logic [127:0] mk [11];
  logic [127:0] got [11];
  localparam logic [127:0] A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_expansion dut (.clk(clk), .reset(reset), .start(start), .key(key),
                     .roundKey(roundKey), .round(round), .valid(valid), .done(done));

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
      sb_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
        t[31:24] ^= rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic load_expect(input logic [127:0] k);
    model(k);
    q.delete();
    for (int r = 0; r < 11; r++) q.push_back(exp_t'{mk[r], 4'(r), r == 10});
  endtask

  task automatic start_key(input logic [127:0] k);
    key = k;
    load_expect(k);
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic finish_run();
    int cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (valid !== 1'b1) break;
      got[round] = roundKey;
      cnt++;
    end
    check("valid_cycles", 128'(cnt), 128'd11);
    check("done_after", 128'(done), 128'd1);
    check("key_hold", roundKey, mk[10]);
    check("round_hold", 128'(round), 128'd10);
  endtask

  task automatic wait_round(input int r);
    bit hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      hit = (valid === 1'b1) && (round == 4'(r));
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL wait_round: got timeout want round %0d", r);
    end
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got round %0d want no output", round);
      end else begin
        e = q.pop_front();
        check("sb_key", roundKey, e.k);
        check("sb_round", 128'(round), 128'(e.r));
        check("sb_done", 128'(done), 128'(e.d));
      end
    end
  end

  initial begin
    build_sbox();
    #1 reset = 1'b0;
    start = 1'b1;
    key = A1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_key", roundKey, 128'd0);
    check("rst_round", 128'(round), 128'd0);
    check("rst_valid", 128'(valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    load_expect(A1);
    reset = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    finish_run();
    check("a1_round0", got[0], A1);

    start_key(A1);
    finish_run();
    check("a1_round1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("a1_round10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    start_key(A1);
    wait_round(10);
    start_key(A1);
    finish_run();
    check("b2b_round1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("b2b_round10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    start_key(A1);
    wait_round(5);
    start_key(128'd0);
    finish_run();
    check("zero_round0", got[0], 128'd0);
    check("zero_round1", got[1], 128'h62636363626363636263636362636363);

    start_key({$urandom, $urandom, $urandom, $urandom});
    wait_round(7);
    q.delete();
    reset = 1'b0;
    #1;
    check("arst_key", roundKey, 128'd0);
    check("arst_round", 128'(round), 128'd0);
    check("arst_valid", 128'(valid), 128'd0);
    check("arst_done", 128'(done), 128'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_key", roundKey, 128'd0);
    check("idle_valid", 128'(valid), 128'd0);
    check("idle_done", 128'(done), 128'd0);
    #2;

    for (int i = 0; i < 6; i++) begin
      start_key({$urandom, $urandom, $urandom, $urandom});
      finish_run();
    end
    for (int i = 0; i < 3; i++) begin
      start_key({$urandom, $urandom, $urandom, $urandom});
      wait_round(int'($urandom_range(0, 10)));
      start_key({$urandom, $urandom, $urandom, $urandom});
      finish_run();
    end
    check("queue_drained", 128'(q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
